// File: rtl/bp_sacc_pkg.sv
// Shared definitions for the scratchpad vector dot-product / elementwise engine:
// CSR offsets, operation and status encodings, and engine FSM states.
package bp_sacc_pkg;

  localparam logic [7:0] CsrAPtr   = 8'h00;
  localparam logic [7:0] CsrBPtr   = 8'h08;
  localparam logic [7:0] CsrLen    = 8'h10;
  localparam logic [7:0] CsrStart  = 8'h18;
  localparam logic [7:0] CsrStatus = 8'h20;
  localparam logic [7:0] CsrResPtr = 8'h28;
  localparam logic [7:0] CsrOp     = 8'h30;

  typedef enum logic [1:0] {
    OpDot = 2'd0,
    OpAdd = 2'd1,
    OpMul = 2'd2,
    OpMac = 2'd3
  } sacc_op_e;

  typedef enum logic [1:0] {
    StatIdle  = 2'd0,
    StatBusy  = 2'd1,
    StatError = 2'd2
  } sacc_status_e;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRdA,
    StRdB,
    StExec,
    StRdAcc,
    StWr,
    StDone
  } sacc_state_e;

  // Dot and MAC produce a single result word; add and multiply produce len words.
  function automatic logic is_scalar(sacc_op_e op);
    return (op == OpDot) || (op == OpMac);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous scratchpad: one read or write per cycle, read data
// registered and held until the next read.
module bsg_mem_1rw_sync #(
  parameter int width_p = 64,
  parameter int els_p   = 64
) (
  input  logic                                        clk_i,
  input  logic                                        v_i,
  input  logic                                        w_i,
  input  logic [((els_p > 1) ? $clog2(els_p) : 1)-1:0] addr_i,
  input  logic [width_p-1:0]                          data_i,
  output logic [width_p-1:0]                          data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      mem[addr_i] <= data_i;
    end
    if (v_i && !w_i) begin
      data_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/bp_sacc_vdp_multi.sv
// Scratchpad-attached vector engine: CSR/SPM command port plus a sequential
// single multiplier/adder datapath for dot, elementwise add/mul and MAC.
module bp_sacc_vdp_multi
  import bp_sacc_pkg::*;
#(
  parameter int width_p      = 64,
  parameter int els_p        = 16,
  parameter int spm_els_p    = 64,
  parameter int addr_width_p = 20
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_w_i,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic [width_p-1:0]      cmd_data_i,
  output logic                    resp_v_o,
  input  logic                    resp_yumi_i,
  output logic [width_p-1:0]      resp_data_o,
  output logic                    done_o
);

  localparam int IdxW = (spm_els_p > 1) ? $clog2(spm_els_p) : 1;
  localparam int CntW = $clog2(els_p + 1);

  sacc_state_e        state_q;
  sacc_op_e           op_q;
  sacc_status_e       status_q;
  logic [width_p-1:0] a_ptr_q, b_ptr_q, len_q, res_ptr_q;
  logic [width_p-1:0] acc_q, a_q, res_q;
  logic [CntW-1:0]    i_q;
  logic               err_q, pend_q, resp_v_q, done_q;
  logic [width_p-1:0] resp_data_q;

  logic               spm_sel, busy, cmd_fire, csr_hi_zero;
  logic [7:0]         csr_off;
  logic [width_p-1:0] csr_rdata;
  logic               mem_v, mem_w;
  logic [IdxW-1:0]    mem_addr, i_idx;
  logic [width_p-1:0] mem_wdata, mem_rdata;
  logic [width_p-1:0] prod, add_x, add_y, sum;
  logic [width_p:0]   a_end, b_end, r_end;
  logic               check_err, last;

  assign spm_sel     = cmd_addr_i[addr_width_p-1];
  assign busy        = (state_q != StIdle);
  // SPM commands stall while the engine owns the scratchpad port.
  assign cmd_ready_o = !resp_v_q && !pend_q && !(busy && spm_sel);
  assign cmd_fire    = cmd_v_i && cmd_ready_o;
  assign csr_hi_zero = (cmd_addr_i[addr_width_p-2:8] == '0);
  assign csr_off     = cmd_addr_i[7:0];

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign done_o      = done_q;

  always_comb begin
    csr_rdata = '0;
    if (csr_hi_zero) begin
      case (csr_off)
        CsrAPtr:   csr_rdata = a_ptr_q;
        CsrBPtr:   csr_rdata = b_ptr_q;
        CsrLen:    csr_rdata = len_q;
        CsrStatus: csr_rdata = width_p'(status_q);
        CsrResPtr: csr_rdata = res_ptr_q;
        CsrOp:     csr_rdata = width_p'(op_q);
        default:   csr_rdata = '0;
      endcase
    end
  end

  assign a_end     = {1'b0, a_ptr_q >> 3} + {1'b0, len_q};
  assign b_end     = {1'b0, b_ptr_q >> 3} + {1'b0, len_q};
  assign r_end     = {1'b0, res_ptr_q >> 3} + {1'b0, len_q};
  assign check_err = (len_q == '0) || (len_q > width_p'(els_p)) ||
                     (a_end > (width_p+1)'(spm_els_p)) ||
                     (b_end > (width_p+1)'(spm_els_p)) ||
                     (r_end > (width_p+1)'(spm_els_p));
  assign last      = (width_p'(i_q) == (len_q - width_p'(1)));
  assign i_idx     = IdxW'(i_q);

  // One multiplier and one adder; the adder is steered by state and op.
  assign prod = a_q * mem_rdata;
  always_comb begin
    add_x = acc_q;
    add_y = prod;
    if (state_q == StWr) begin
      add_y = mem_rdata;
    end else if (op_q == OpAdd) begin
      add_x = a_q;
      add_y = mem_rdata;
    end
  end
  assign sum = add_x + add_y;

  always_comb begin
    mem_v     = 1'b0;
    mem_w     = 1'b0;
    mem_addr  = cmd_addr_i[3 +: IdxW];
    mem_wdata = cmd_data_i;
    if (busy) begin
      unique case (state_q)
        StRdA: begin
          mem_v    = 1'b1;
          mem_addr = a_ptr_q[3 +: IdxW] + i_idx;
        end
        StRdB: begin
          mem_v    = 1'b1;
          mem_addr = b_ptr_q[3 +: IdxW] + i_idx;
        end
        StRdAcc: begin
          mem_v    = 1'b1;
          mem_addr = res_ptr_q[3 +: IdxW];
        end
        StWr: begin
          mem_v    = 1'b1;
          mem_w    = 1'b1;
          mem_addr = is_scalar(op_q) ? res_ptr_q[3 +: IdxW] : res_ptr_q[3 +: IdxW] + i_idx;
          unique case (op_q)
            OpDot:   mem_wdata = acc_q;
            OpMac:   mem_wdata = sum;
            default: mem_wdata = res_q;
          endcase
        end
        default: mem_v = 1'b0;
      endcase
    end else if (cmd_fire && spm_sel) begin
      mem_v = 1'b1;
      mem_w = cmd_w_i;
    end
  end

  bsg_mem_1rw_sync #(
    .width_p (width_p),
    .els_p   (spm_els_p)
  ) spm (
    .clk_i  (clk_i),
    .v_i    (mem_v),
    .w_i    (mem_w),
    .addr_i (mem_addr),
    .data_i (mem_wdata),
    .data_o (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      op_q        <= OpDot;
      status_q    <= StatIdle;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      len_q       <= '0;
      res_ptr_q   <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      res_q       <= '0;
      i_q         <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (resp_v_q && resp_yumi_i) begin
        resp_v_q <= 1'b0;
      end
      if (pend_q) begin
        pend_q      <= 1'b0;
        resp_v_q    <= 1'b1;
        resp_data_q <= mem_rdata;
      end
      if (cmd_fire) begin
        if (spm_sel && !cmd_w_i) begin
          pend_q <= 1'b1;
        end else begin
          resp_v_q    <= 1'b1;
          resp_data_q <= (spm_sel || cmd_w_i) ? '0 : csr_rdata;
        end
        if (!spm_sel && cmd_w_i && !busy && csr_hi_zero) begin
          case (csr_off)
            CsrAPtr:   a_ptr_q   <= cmd_data_i;
            CsrBPtr:   b_ptr_q   <= cmd_data_i;
            CsrLen:    len_q     <= cmd_data_i;
            CsrResPtr: res_ptr_q <= cmd_data_i;
            CsrOp:     op_q      <= sacc_op_e'(cmd_data_i[1:0]);
            CsrStart: begin
              state_q  <= StCheck;
              status_q <= StatBusy;
            end
            default: ;
          endcase
        end
      end

      case (state_q)
        StCheck: begin
          err_q <= check_err;
          i_q   <= '0;
          acc_q <= '0;
          state_q <= check_err ? StDone : StRdA;
        end
        StRdA: state_q <= StRdB;
        StRdB: begin
          a_q     <= mem_rdata;
          state_q <= StExec;
        end
        StExec: begin
          if (!is_scalar(op_q)) begin
            res_q   <= (op_q == OpAdd) ? sum : prod;
            state_q <= StWr;
          end else begin
            acc_q <= sum;
            if (last) begin
              state_q <= (op_q == OpMac) ? StRdAcc : StWr;
            end else begin
              i_q     <= i_q + CntW'(1);
              state_q <= StRdA;
            end
          end
        end
        StRdAcc: state_q <= StWr;
        StWr: begin
          if (is_scalar(op_q) || last) begin
            state_q <= StDone;
          end else begin
            i_q     <= i_q + CntW'(1);
            state_q <= StRdA;
          end
        end
        StDone: begin
          done_q   <= 1'b1;
          status_q <= err_q ? StatError : StatIdle;
          state_q  <= StIdle;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_vdp_multi.sv
// Directed bench for bp_sacc_vdp_multi: CSR/SPM access latency, every op,
// error checks, busy behaviour, wrap-around and reset mid-operation.
module tb_bp_sacc_vdp_multi;

  localparam int W   = 64;
  localparam int ELS = 16;
  localparam int SPM = 128;
  localparam int AW  = 20;
  localparam logic [AW-1:0] SpmBase = 20'h80000;

  logic          clk, reset;
  logic          cmd_v, cmd_w, resp_yumi;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_data;
  logic          cmd_ready_o, resp_v_o, done_o;
  logic [W-1:0]  resp_data_o;

  int n_checks = 0;
  int n_fails  = 0;

  bp_sacc_vdp_multi #(
    .width_p      (W),
    .els_p        (ELS),
    .spm_els_p    (SPM),
    .addr_width_p (AW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_v_i     (cmd_v),
    .cmd_ready_o (cmd_ready_o),
    .cmd_w_i     (cmd_w),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .resp_v_o    (resp_v_o),
    .resp_yumi_i (resp_yumi),
    .resp_data_o (resp_data_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_cmd(input logic w, input logic [AW-1:0] addr, input logic [W-1:0] data,
                        output logic [W-1:0] rdata, output int lat);
    int n;
    rdata = '0;
    lat   = 0;
    @(negedge clk);
    cmd_v = 1'b1; cmd_w = w; cmd_addr = addr; cmd_data = data;
    n = 0;
    #1;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready_o) begin
      n_checks++; n_fails++;
      $display("FAIL cmd_accept addr=%h: ready=%b required 1", addr, cmd_ready_o);
      cmd_v = 1'b0;
      return;
    end
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      cmd_v = 1'b0;
      n++;
    end while (!resp_v_o && n < 20);
    lat = n;
    if (!resp_v_o) begin
      n_checks++; n_fails++;
      $display("FAIL cmd_resp addr=%h: resp_v=%b required 1", addr, resp_v_o);
      return;
    end
    rdata = resp_data_o;
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
  endtask

  task automatic csr_wr(input logic [7:0] off, input logic [W-1:0] data);
    logic [W-1:0] d; int l;
    do_cmd(1'b1, {12'h0, off}, data, d, l);
  endtask

  task automatic csr_rd(input logic [7:0] off, output logic [W-1:0] data);
    int l;
    do_cmd(1'b0, {12'h0, off}, '0, data, l);
  endtask

  task automatic spm_wr(input logic [AW-1:0] byte_addr, input logic [W-1:0] data);
    logic [W-1:0] d; int l;
    do_cmd(1'b1, SpmBase | byte_addr, data, d, l);
  endtask

  task automatic spm_rd(input logic [AW-1:0] byte_addr, output logic [W-1:0] data);
    int l;
    do_cmd(1'b0, SpmBase | byte_addr, '0, data, l);
  endtask

  task automatic setup_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] len,
                          input logic [W-1:0] op, input logic [W-1:0] res);
    csr_wr(8'h00, a);
    csr_wr(8'h08, b);
    csr_wr(8'h10, len);
    csr_wr(8'h30, op);
    csr_wr(8'h28, res);
  endtask

  task automatic wait_done(input int bound, output logic seen, output int cycles);
    seen = done_o; cycles = 0;
    while (!seen && cycles < bound) begin
      @(negedge clk);
      cycles++;
      seen = done_o;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    reset = 1'b1; cmd_v = 1'b0; cmd_w = 1'b0; cmd_addr = '0; cmd_data = '0; resp_yumi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready_o !== 1'b1 || resp_v_o !== 1'b0 || done_o !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: ready=%b resp_v=%b done=%b required 1 0 0",
               cmd_ready_o, resp_v_o, done_o);
    end
    csr_rd(8'h20, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL reset_status: got %0d required 0", d); end
    csr_rd(8'h10, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL reset_len: got %0d required 0", d); end
  endtask

  task automatic test_latency();
    logic [W-1:0] d; int l;
    do_cmd(1'b1, 20'h00000, 64'h40, d, l);
    n_checks++;
    if (l !== 1 || d !== 64'd0) begin
      n_fails++; $display("FAIL csr_wr_latency: lat=%0d data=%0d required 1 0", l, d);
    end
    do_cmd(1'b0, 20'h00000, '0, d, l);
    n_checks++;
    if (l !== 1 || d !== 64'h40) begin
      n_fails++; $display("FAIL csr_rd_latency: lat=%0d data=%h required 1 40", l, d);
    end
    do_cmd(1'b1, SpmBase | 20'h0, 64'd1, d, l);
    n_checks++;
    if (l !== 1 || d !== 64'd0) begin
      n_fails++; $display("FAIL spm_wr_latency: lat=%0d data=%0d required 1 0", l, d);
    end
    do_cmd(1'b0, SpmBase | 20'h0, '0, d, l);
    n_checks++;
    if (l !== 2 || d !== 64'd1) begin
      n_fails++; $display("FAIL spm_rd_latency: lat=%0d data=%0d required 2 1", l, d);
    end
    // Low three address bits are ignored.
    do_cmd(1'b0, SpmBase | 20'h5, '0, d, l);
    n_checks++;
    if (d !== 64'd1) begin n_fails++; $display("FAIL spm_low_bits: got %0d required 1", d); end
    csr_rd(8'h18, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL start_reads_zero: got %0d required 0", d); end
    csr_wr(8'h38, 64'h55);
    csr_rd(8'h38, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL undef_csr: got %0d required 0", d); end
    for (int i = 0; i < 4; i++) begin
      spm_wr(AW'(8 * i), W'(i + 1));
      spm_wr(AW'(20'h100 + 8 * i), W'(i + 5));
    end
  endtask

  task automatic test_dot();
    logic [W-1:0] d; logic seen; int c;
    setup_op(64'h0, 64'h100, 64'd4, 64'd0, 64'h200);
    csr_wr(8'h18, 64'd1);
    wait_done(100, seen, c);
    n_checks++;
    if (seen !== 1'b1) begin n_fails++; $display("FAIL dot_done: done=%b required 1", seen); end
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0) begin n_fails++; $display("FAIL dot_done_pulse: done=%b required 0", done_o); end
    spm_rd(20'h200, d);
    n_checks++;
    if (d !== 64'd70) begin n_fails++; $display("FAIL dot_result: got %0d required 70", d); end
    csr_rd(8'h20, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL dot_status: got %0d required 0", d); end
  endtask

  task automatic test_elementwise(input logic [W-1:0] op, input logic [AW-1:0] res);
    logic [W-1:0] d, exp; logic seen; int c;
    setup_op(64'h0, 64'h100, 64'd4, op, W'(res));
    csr_wr(8'h18, 64'd1);
    wait_done(200, seen, c);
    n_checks++;
    if (seen !== 1'b1) begin n_fails++; $display("FAIL ew_done op=%0d: done=%b required 1", op, seen); end
    for (int i = 0; i < 4; i++) begin
      exp = (op == 64'd1) ? W'(2 * i + 6) : W'((i + 1) * (i + 5));
      spm_rd(res + AW'(8 * i), d);
      n_checks++;
      if (d !== exp) begin
        n_fails++; $display("FAIL ew_result op=%0d i=%0d: got %0d required %0d", op, i, d, exp);
      end
    end
  endtask

  task automatic test_mac();
    logic [W-1:0] d; logic seen; int c;
    spm_wr(20'h200, 64'd100);
    setup_op(64'h0, 64'h100, 64'd4, 64'd3, 64'h200);
    csr_wr(8'h18, 64'd1);
    wait_done(100, seen, c);
    spm_rd(20'h200, d);
    n_checks++;
    if (seen !== 1'b1 || d !== 64'd170) begin
      n_fails++; $display("FAIL mac_result: done=%b got %0d required 1 170", seen, d);
    end
  endtask

  task automatic test_busy_csr_write();
    logic [W-1:0] d; logic seen; int c;
    spm_wr(20'h280, 64'd0);
    setup_op(64'h0, 64'h100, 64'd4, 64'd0, 64'h280);
    csr_wr(8'h18, 64'd1);
    csr_wr(8'h10, 64'd1);
    wait_done(100, seen, c);
    csr_rd(8'h10, d);
    n_checks++;
    if (d !== 64'd4) begin n_fails++; $display("FAIL busy_write_ignored: len=%0d required 4", d); end
    spm_rd(20'h280, d);
    n_checks++;
    if (seen !== 1'b1 || d !== 64'd70) begin
      n_fails++; $display("FAIL busy_result: done=%b got %0d required 1 70", seen, d);
    end
  endtask

  task automatic test_errors();
    logic [W-1:0] d; logic seen; int c;
    logic [W-1:0] lens [3];
    logic [W-1:0] aps  [3];
    lens[0] = 64'd0; lens[1] = 64'd17; lens[2] = 64'd4;
    aps[0]  = 64'h0; aps[1]  = 64'h0;  aps[2]  = 64'h3F8;
    for (int k = 0; k < 3; k++) begin
      setup_op(aps[k], 64'h100, lens[k], 64'd0, 64'h200);
      csr_wr(8'h18, 64'd1);
      wait_done(3, seen, c);
      n_checks++;
      if (seen !== 1'b1) begin n_fails++; $display("FAIL err_done case=%0d: done=%b required 1", k, seen); end
      @(negedge clk);
      csr_rd(8'h20, d);
      n_checks++;
      if (d !== 64'd2) begin n_fails++; $display("FAIL err_status case=%0d: got %0d required 2", k, d); end
    end
    csr_rd(8'h20, d);
    n_checks++;
    if (d !== 64'd2) begin n_fails++; $display("FAIL err_persist: got %0d required 2", d); end
    spm_rd(20'h200, d);
    n_checks++;
    if (d !== 64'd170) begin n_fails++; $display("FAIL err_spm_unchanged: got %0d required 170", d); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] d; logic seen; int c;
    spm_wr(20'h300, 64'h8000_0000_0000_0000);
    spm_wr(20'h308, 64'h8000_0000_0000_0000);
    spm_wr(20'h310, 64'd5);
    setup_op(64'h300, 64'h308, 64'd1, 64'd0, 64'h310);
    csr_wr(8'h18, 64'd1);
    wait_done(100, seen, c);
    spm_rd(20'h310, d);
    n_checks++;
    if (seen !== 1'b1 || d !== 64'd0) begin
      n_fails++; $display("FAIL wrap_result: done=%b got %0d required 1 0", seen, d);
    end
    csr_rd(8'h20, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL wrap_status_cleared: got %0d required 0", d); end
  endtask

  task automatic test_midop_reset();
    logic [W-1:0] d;
    spm_wr(20'h200, 64'hDEAD);
    setup_op(64'h0, 64'h100, 64'd4, 64'd0, 64'h200);
    csr_wr(8'h18, 64'd1);
    @(negedge clk);
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = SpmBase | 20'h200;
    #1;
    n_checks++;
    if (cmd_ready_o !== 1'b0) begin
      n_fails++; $display("FAIL busy_spm_stall: ready=%b required 0", cmd_ready_o);
    end
    cmd_v = 1'b0;
    csr_rd(8'h20, d);
    n_checks++;
    if (d !== 64'd1) begin n_fails++; $display("FAIL busy_status: got %0d required 1", d); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    csr_rd(8'h20, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL midreset_status: got %0d required 0", d); end
    csr_rd(8'h28, d);
    n_checks++;
    if (d !== 64'd0) begin n_fails++; $display("FAIL midreset_csr: got %h required 0", d); end
    spm_rd(20'h200, d);
    n_checks++;
    if (d !== 64'hDEAD) begin n_fails++; $display("FAIL midreset_no_write: got %h required dead", d); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_dot();
    test_elementwise(64'd1, 20'h200);
    test_elementwise(64'd2, 20'h240);
    test_mac();
    test_busy_csr_write();
    test_errors();
    test_wrap();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bp_sacc_vdp_multi.md
BP_SACC_VDP_MULTI -- requirements
Module: bp_sacc_vdp_multi

Interface
REQ-001 Parameter width_p, default 64: element and data width, in bits.
REQ-002 Parameter els_p, default 16: maximum vector length.
REQ-003 Parameter spm_els_p, default 64: scratchpad depth, in width_p words.
REQ-004 Parameter addr_width_p, default 20: command address width.
REQ-005 clk_i  in  1  the single clock.
REQ-006 reset_i  in  1  reset; asynchronous, active-high.
REQ-007 cmd_v_i / cmd_ready_o  in/out  1  command valid/ready.
REQ-008 cmd_w_i  in  1  1=write, 0=read.
REQ-009 cmd_addr_i  in  addr_width_p  bit[addr_width_p-1]=1 selects SPM, 0 selects CSR; byte address.
REQ-010 cmd_data_i  in  width_p  write data.
REQ-011 resp_v_o / resp_yumi_i  out/in  1  response valid / consumed.
REQ-012 resp_data_o  out  width_p  read data; 0 for writes.
REQ-013 done_o  out  1  one-cycle pulse at operation completion or error.

Function
REQ-014 CSR map: 0x00 a_ptr, 0x08 b_ptr, 0x10 len, 0x18 start (write-only, reads 0), 0x20 status (read-only), 0x28 res_ptr, 0x30 op; other offsets: writes ignored, reads 0.
REQ-015 status encoding: 0=idle, 1=busy, 2=error; 2 persists until the next start.
REQ-016 op encoding: 0=dot product (scalar to res_ptr); 1=elementwise add; 2=elementwise multiply (len words to res_ptr+8i); 3=multiply-accumulate (res += dot, read-modify-write at res_ptr).
REQ-017 Exactly one response per accepted command; cmd_ready_o=0 while resp_v_o=1 or a response is pending.
REQ-018 CSR access latency: response 1 cycle after acceptance; SPM read: 2 cycles; SPM write: 1 cycle.
REQ-019 While busy: cmd_ready_o=0 for SPM-targeted commands; CSR reads are allowed; CSR writes are acknowledged and ignored.
REQ-020 Writing any value to start while idle/error begins an operation; the engine owns the SPM port.
REQ-021 FSM states: IDLE, CHECK, RD_A, RD_B, EXEC, RD_ACC, WR, DONE.
REQ-022 IDLE->CHECK on start write.
REQ-023 CHECK->DONE with error if len==0, len>els_p, or any pointer word index plus len exceeds spm_els_p; otherwise CHECK->RD_A with i=0 and acc=0.
REQ-024 RD_A->RD_B->EXEC: each read is 1 cycle request plus 1 cycle data.
REQ-025 EXEC, ops 1/2 -> WR of element i; EXEC, ops 0/3 -> accumulate, then next element or, on the last element, RD_ACC (op 3) / WR (op 0).
REQ-026 WR: i==len-1 or scalar result -> DONE; else i++ and -> RD_A.
REQ-027 DONE: pulse done_o, set status, -> IDLE.
REQ-028 Arithmetic: products and sums truncated to width_p (modulo 2^width_p); unsigned.
REQ-029 SPM word index = byte address >> 3; the low 3 bits are ignored.
REQ-030 Start and SPM command in the same cycle while idle: the command is accepted first; start takes effect on the next cycle.

Reset
REQ-031 On reset: state=IDLE; all CSRs=0; status=0; acc=0; resp_v_o=0; done_o=0; cmd_ready_o=1 after deassertion.
REQ-032 Reset mid-operation aborts immediately; no further SPM writes occur; SPM contents are undefined-preserved (not cleared).

Structure
REQ-033 CSR offset constants, the op enum and the status enum belong in bp_common_pkg-style shared package bp_sacc_pkg.
REQ-034 The SPM is a single sub-module instance, bsg_mem_1rw_sync (width_p x spm_els_p).
REQ-035 The datapath is a single multiplier plus adder, sequential (no reduction tree).

Verification
REQ-036 SPM a=[1..4] at 0x0, b=[5..8] at 0x100, len=4, op=0, res_ptr=0x200, start -> done_o pulse; SPM[0x200]=70; status=0.
REQ-037 Same vectors, op=1, res_ptr=0x200 -> SPM 0x200..0x218 = 6,8,10,12.
REQ-038 op=3, SPM[0x200]=100 preloaded, same vectors -> SPM[0x200]=170.
REQ-039 len=0 or len=els_p+1, start -> done_o within 3 cycles; status=2; SPM unchanged.
REQ-040 Mid-operation SPM read -> stalled (cmd_ready_o=0); status read returns 1; reset asserted mid-op -> status=0, the result word is not written.
REQ-041 a=b=[2^63] (width 64), op=0, len=1 -> result 0 (wrap).
